// File: rtl/spi_slave_core_pkg.sv
// Shared types and constants for the SPI responder.
package spi_slave_core_pkg;

  localparam int unsigned SPI_MAX_CHAR_LEN = 32;

  // Mode number is {cpol, cpha}.
  typedef enum logic [1:0] {
    SpiMode0 = 2'd0,
    SpiMode1 = 2'd1,
    SpiMode2 = 2'd2,
    SpiMode3 = 2'd3
  } spi_mode_e;

  typedef enum logic {
    StIdle   = 1'b0,
    StActive = 1'b1
  } spi_state_e;

  function automatic spi_mode_e spi_mode(input logic cpol, input logic cpha);
    return spi_mode_e'({cpol, cpha});
  endfunction

endpackage

// File: rtl/spi_slave_core_sync_edge.sv
// Multi-stage synchronizer for an asynchronous pin, plus rise/fall pulse detection.
// Resets to 0 so a pin already low at reset release never looks like a falling edge.
module spi_slave_core_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic wb_clk,
  input  logic wb_reset,
  input  logic i_d,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_dly;
  logic                   w_q;

  assign w_q = r_sync[SYNC_STAGES-1];

  // Synchronizer chain plus one extra delay flop for edge comparison.
  always_ff @(posedge wb_clk or posedge wb_reset) begin
    if (wb_reset) begin
      r_sync <= '0;
      r_dly  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
      r_dly  <= w_q;
    end
  end

  assign o_rise = w_q & ~r_dly;
  assign o_fall = ~w_q & r_dly;

endmodule

// File: rtl/spi_slave_core.sv
// SPI responder: oversamples sclk/cs_n/mosi in the wb_clk domain, receives words into rx_data
// and returns words from the TX holding register on miso, in all four CPOL/CPHA modes.
module spi_slave_core
  import spi_slave_core_pkg::*;
#(
  parameter int unsigned CHAR_LEN    = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          LSB_FIRST   = 1'b0
) (
  input  logic                wb_clk,
  input  logic                wb_reset,
  input  logic                cpol,
  input  logic                cpha,
  input  logic [CHAR_LEN-1:0] tx_data,
  input  logic                tx_valid,
  output logic                tx_ready,
  output logic                tx_underrun,
  output logic [CHAR_LEN-1:0] rx_data,
  output logic                rx_valid,
  input  logic                rx_ack,
  output logic                rx_overrun,
  output logic                busy,
  input  logic                sclk_i,
  input  logic                cs_n_i,
  input  logic                mosi_i,
  output logic                miso_o,
  output logic                miso_oe
);

  localparam int unsigned     CntW    = $clog2(SPI_MAX_CHAR_LEN + 1);
  localparam logic [CntW-1:0] LastBit = CntW'(CHAR_LEN - 1);

  function automatic logic head_bit(input logic [CHAR_LEN-1:0] v);
    return LSB_FIRST ? v[0] : v[CHAR_LEN-1];
  endfunction

  function automatic logic [CHAR_LEN-1:0] advance(input logic [CHAR_LEN-1:0] v);
    return LSB_FIRST ? (v >> 1) : (v << 1);
  endfunction

  logic w_sclk_rise, w_sclk_fall, w_cs_rise, w_cs_fall;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic w_mosi;

  spi_slave_core_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
    .wb_clk  (wb_clk),
    .wb_reset(wb_reset),
    .i_d     (sclk_i),
    .o_rise  (w_sclk_rise),
    .o_fall  (w_sclk_fall)
  );

  spi_slave_core_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_cs_sync (
    .wb_clk  (wb_clk),
    .wb_reset(wb_reset),
    .i_d     (cs_n_i),
    .o_rise  (w_cs_rise),
    .o_fall  (w_cs_fall)
  );

  // mosi synchronizer of equal depth so its last stage lines up with the sclk edge pulses.
  always_ff @(posedge wb_clk or posedge wb_reset) begin
    if (wb_reset) r_mosi_sync <= '0;
    else          r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi_i};
  end

  assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

  spi_mode_e w_mode;
  logic      w_lead, w_trail, w_sample, w_shift;

  assign w_mode = spi_mode(cpol, cpha);

  // Map sclk rise/fall onto leading/trailing edges for the selected polarity.
  always_comb begin
    w_lead  = 1'b0;
    w_trail = 1'b0;
    unique case (w_mode)
      SpiMode0, SpiMode1: begin
        w_lead  = w_sclk_rise;
        w_trail = w_sclk_fall;
      end
      SpiMode2, SpiMode3: begin
        w_lead  = w_sclk_fall;
        w_trail = w_sclk_rise;
      end
    endcase
  end

  assign w_sample = cpha ? w_trail : w_lead;
  assign w_shift  = cpha ? w_lead  : w_trail;

  spi_state_e          r_state, w_state_next;
  logic [CntW-1:0]     r_bit_cnt;
  logic                w_word_start, w_first_start, w_sample_en, w_shift_en, w_complete, w_abort;

  // FSM state register.
  always_ff @(posedge wb_clk or posedge wb_reset) begin
    if (wb_reset) r_state <= StIdle;
    else          r_state <= w_state_next;
  end

  // Next state and per-cycle strobes; sclk edges only matter while selected.
  always_comb begin
    w_state_next  = r_state;
    w_word_start  = 1'b0;
    w_first_start = 1'b0;
    w_sample_en   = 1'b0;
    w_shift_en    = 1'b0;
    w_complete    = 1'b0;
    w_abort       = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_cs_fall) begin
          w_state_next  = StActive;
          w_word_start  = 1'b1;
          w_first_start = 1'b1;
        end
      end
      StActive: begin
        if (w_cs_rise) begin
          w_state_next = StIdle;
          w_abort      = 1'b1;
        end else begin
          w_sample_en  = w_sample;
          w_shift_en   = w_shift;
          w_complete   = w_sample && (r_bit_cnt == LastBit);
          w_word_start = w_complete;
        end
      end
    endcase
  end

  logic [CHAR_LEN-1:0] r_rx_shift, w_rx_next, r_rx_data;
  logic                r_rx_valid, r_rx_overrun;

  assign w_rx_next = LSB_FIRST ? {w_mosi, r_rx_shift[CHAR_LEN-1:1]}
                               : {r_rx_shift[CHAR_LEN-2:0], w_mosi};

  // Receive shifter and bit counter; a deselect drops any partial word.
  always_ff @(posedge wb_clk or posedge wb_reset) begin
    if (wb_reset) begin
      r_bit_cnt  <= '0;
      r_rx_shift <= '0;
    end else if (w_abort || w_first_start) begin
      r_bit_cnt  <= '0;
      r_rx_shift <= '0;
    end else if (w_sample_en) begin
      r_bit_cnt  <= w_complete ? '0 : r_bit_cnt + 1'b1;
      r_rx_shift <= w_rx_next;
    end
  end

  // RX handshake: a completing word wins over a same-cycle rx_ack.
  always_ff @(posedge wb_clk or posedge wb_reset) begin
    if (wb_reset) begin
      r_rx_data    <= '0;
      r_rx_valid   <= 1'b0;
      r_rx_overrun <= 1'b0;
    end else begin
      r_rx_overrun <= 1'b0;
      if (w_complete) begin
        r_rx_data    <= w_rx_next;
        r_rx_valid   <= 1'b1;
        r_rx_overrun <= r_rx_valid && !rx_ack;
      end else if (rx_ack) begin
        r_rx_valid <= 1'b0;
      end
    end
  end

  logic [CHAR_LEN-1:0] r_tx_hold, r_tx_shift, w_tx_word;
  logic                r_tx_full, r_tx_underrun, r_miso, w_tx_load;

  assign w_tx_load = tx_valid && !r_tx_full;
  assign w_tx_word = r_tx_full ? r_tx_hold : '0;

  // TX holding register and output shifter. r_tx_shift holds the bits not yet on miso, so a
  // back-to-back word start in cpha=0 leaves bit 0 for the following shift edge.
  always_ff @(posedge wb_clk or posedge wb_reset) begin
    if (wb_reset) begin
      r_tx_hold     <= '0;
      r_tx_full     <= 1'b0;
      r_tx_underrun <= 1'b0;
      r_tx_shift    <= '0;
      r_miso        <= 1'b0;
    end else begin
      r_tx_underrun <= w_word_start && !r_tx_full;
      if (w_tx_load) r_tx_hold <= tx_data;
      r_tx_full <= w_word_start ? w_tx_load : (r_tx_full | w_tx_load);
      if (w_abort) begin
        r_miso <= 1'b0;
      end else if (w_word_start) begin
        if (w_first_start && !cpha) begin
          r_miso     <= head_bit(w_tx_word);
          r_tx_shift <= advance(w_tx_word);
        end else begin
          r_tx_shift <= w_tx_word;
        end
      end else if (w_shift_en) begin
        r_miso     <= head_bit(r_tx_shift);
        r_tx_shift <= advance(r_tx_shift);
      end
    end
  end

  assign tx_ready    = !r_tx_full;
  assign tx_underrun = r_tx_underrun;
  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign rx_overrun  = r_rx_overrun;
  assign busy        = (r_state == StActive);
  assign miso_oe     = busy;
  assign miso_o      = r_miso;

endmodule

// File: tb/tb_spi_slave_core.sv
// Scoreboard bench for spi_slave_core: a bit-banged SPI master drives the pins while a reference
// model predicts received words, returned words and underrun/overrun pulse counts.
module tb_spi_slave_core;

  localparam int HALF = 8;

  logic       wb_clk = 1'b0;
  logic       wb_reset = 1'b1;
  logic       cpol = 1'b0, cpha = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0, rx_ack = 1'b0;
  logic       sclk_i = 1'b0, cs_n_i = 1'b1, mosi_i = 1'b0;
  logic       tx_ready, tx_underrun, rx_valid, rx_overrun, busy, miso_o, miso_oe;
  logic [7:0] rx_data;

  spi_slave_core dut (
    .wb_clk     (wb_clk),
    .wb_reset   (wb_reset),
    .cpol       (cpol),
    .cpha       (cpha),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_underrun(tx_underrun),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ack     (rx_ack),
    .rx_overrun (rx_overrun),
    .busy       (busy),
    .sclk_i     (sclk_i),
    .cs_n_i     (cs_n_i),
    .mosi_i     (mosi_i),
    .miso_o     (miso_o),
    .miso_oe    (miso_oe)
  );

  always #5 wb_clk = ~wb_clk;

  int         n_vec = 0, n_err = 0, n_und = 0, n_ovr = 0;
  int         exp_und, exp_ovr;
  bit         auto_ack = 1'b1, model_unread = 1'b0, dead = 1'b0, prev_valid = 1'b0;
  logic [7:0] q_hold[$];
  logic [7:0] q_rx_exp[$];
  logic [7:0] m_words[4];
  logic [7:0] cur_tx, got;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_tx_underrun", tx_underrun, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_overrun", rx_overrun, 0);
    chk("rst_busy", busy, 0);
    chk("rst_miso_o", miso_o, 0);
    chk("rst_miso_oe", miso_oe, 0);
  endtask

  function automatic logic mbit(input int k);
    logic [7:0] w;
    w = m_words[k / 8];
    return w[7 - (k % 8)];
  endfunction

  // Each word start takes the held word, or zeros plus an underrun if nothing is held.
  task automatic take_tx();
    if (q_hold.size() > 0) cur_tx = q_hold.pop_front();
    else begin
      cur_tx = 8'h00;
      exp_und++;
    end
  endtask

  // Master sample instant; the slave samples mosi at this same edge.
  task automatic sample_point(input int k);
    got = {got[6:0], miso_o};
    if ((k % 8 == 7) && !dead) begin
      chk("miso_word", got, cur_tx);
      q_rx_exp.push_back(m_words[k / 8]);
      if (model_unread) exp_ovr++;
      model_unread = !auto_ack;
      take_tx();
    end
  endtask

  task automatic load_tx(input logic [7:0] v);
    int t = 0;
    while (!tx_ready && t < 100) begin
      @(negedge wb_clk);
      t++;
    end
    chk("tx_ready_wait", tx_ready, 1);
    tx_data  = v;
    tx_valid = 1'b1;
    @(negedge wb_clk);
    tx_valid = 1'b0;
    q_hold.push_back(v);
    chk("tx_ready_after_load", tx_ready, 0);
  endtask

  // One chip-select frame of nbits; rst_bit >= 0 pulses wb_reset before that bit.
  task automatic xfer(input bit p, input bit h, input int nbits, input int rst_bit);
    int und0, ovr0;
    und0 = n_und;
    ovr0 = n_ovr;
    exp_und = 0;
    exp_ovr = 0;
    dead = 1'b0;
    got = 8'h00;
    cpol = p;
    cpha = h;
    sclk_i = p;
    repeat (2 * HALF) @(negedge wb_clk);
    cs_n_i = 1'b0;
    mosi_i = h ? 1'b0 : mbit(0);
    take_tx();
    repeat (HALF) @(negedge wb_clk);
    for (int k = 0; k < nbits; k++) begin
      if (k == rst_bit) begin
        wb_reset = 1'b1;
        @(negedge wb_clk);
        chk_reset_vals();
        wb_reset = 1'b0;
        q_hold.delete();
        model_unread = 1'b0;
        dead = 1'b1;
      end
      if (!h) sample_point(k);
      else mosi_i = mbit(k);
      sclk_i = ~p;
      repeat (HALF) @(negedge wb_clk);
      if (h) sample_point(k);
      else if (k + 1 < nbits) mosi_i = mbit(k + 1);
      sclk_i = p;
      repeat (HALF) @(negedge wb_clk);
    end
    cs_n_i = 1'b1;
    repeat (2 * HALF) @(negedge wb_clk);
    chk("underrun_count", n_und - und0, exp_und);
    chk("overrun_count", n_ovr - ovr0, exp_ovr);
    chk("rx_words_missing", q_rx_exp.size(), 0);
    q_rx_exp.delete();
  endtask

  // Monitor: pops the expected word whenever the DUT presents a new rx word.
  initial begin
    forever begin
      @(negedge wb_clk);
      if (!wb_reset && ((rx_valid && !prev_valid) || rx_overrun)) begin
        if (q_rx_exp.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL rx_unexpected: got %02h, expected no word", rx_data);
        end else begin
          chk("rx_data", rx_data, q_rx_exp.pop_front());
        end
      end
      if (tx_underrun) n_und++;
      if (rx_overrun) n_ovr++;
      prev_valid = rx_valid;
      rx_ack = auto_ack && rx_valid;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge wb_clk);
    chk_reset_vals();
    wb_reset = 1'b0;
    repeat (4) @(negedge wb_clk);
    chk_reset_vals();

    // Mode 0 reference case.
    load_tx(8'hA5);
    m_words[0] = 8'h3C;
    xfer(1'b0, 1'b0, 8, -1);

    // Modes 1..3.
    for (int m = 1; m < 4; m++) begin
      load_tx(8'h81);
      m_words[0] = 8'h7E;
      xfer(m[1], m[0], 8, -1);
    end

    // Two back-to-back words with no ack: overwrite plus one overrun.
    auto_ack = 1'b0;
    load_tx(8'($urandom()));
    m_words[0] = 8'($urandom());
    m_words[1] = 8'($urandom());
    xfer(1'b0, 1'b0, 16, -1);
    chk("rx_valid_held", rx_valid, 1);
    auto_ack = 1'b1;
    model_unread = 1'b0;
    repeat (4) @(negedge wb_clk);
    chk("rx_valid_acked", rx_valid, 0);

    // No TX load: underrun and zeros on miso.
    m_words[0] = 8'($urandom());
    xfer(1'b1, 1'b1, 8, -1);

    // Aborted partial word, then a clean word.
    m_words[0] = 8'hFF;
    xfer(1'b0, 1'b1, 5, -1);
    m_words[0] = 8'h55;
    xfer(1'b0, 1'b1, 8, -1);

    // Reset in the middle of a word, then a normal transfer.
    load_tx(8'hC3);
    m_words[0] = 8'($urandom());
    xfer(1'b0, 1'b0, 8, 3);
    load_tx(8'h5A);
    m_words[0] = 8'($urandom());
    xfer(1'b0, 1'b0, 8, -1);

    // Random frames.
    for (int i = 0; i < 10; i++) begin
      int nw;
      bit p, h;
      nw = $urandom_range(1, 3);
      p = 1'($urandom());
      h = 1'($urandom());
      if ($urandom_range(0, 1) == 1) load_tx(8'($urandom()));
      for (int w = 0; w < nw; w++) m_words[w] = 8'($urandom());
      xfer(p, h, nw * 8, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
